// File: rtl/bcd_pkg.sv
// Shared widths, limits and digit type for the single-digit BCD adder.
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add_comb.sv
// Combinational digit adder: ripple full-adder chain, decimal-carry detect and +6 fix-up.
module bcd_digit_add_comb
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] raw_lo,
    output logic             corr,
    output logic [BCD_W-1:0] digit
);

    logic [BCD_W:0]   carry;
    logic [BCD_W-1:0] s;

    assign carry[0] = cin;

    for (genvar i = 0; i < BCD_W; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign raw_lo = s;

    // True exactly when the 5-bit raw sum exceeds 9.
    assign corr   = carry[BCD_W] | (s[3] & (s[2] | s[1]));
    assign digit  = corr ? (s + BCD_CORR) : s;

endmodule

// File: rtl/bcd_adder_df.sv
// Registered single-digit BCD adder; results appear one clock after an accepted input.
module bcd_adder_df
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [BCD_W-1:0] sum,
    output logic [BCD_W-1:0] bcd_sum,
    output logic             cout,
    output logic             err
);

    logic [BCD_W-1:0] raw_lo_c;
    logic [BCD_W-1:0] digit_c;
    logic             corr_c;
    logic             err_c;

    bcd_digit_add_comb u_add (
        .a      (a),
        .b      (b),
        .cin    (cin),
        .raw_lo (raw_lo_c),
        .corr   (corr_c),
        .digit  (digit_c)
    );

    // Illegal digits are flagged but the arithmetic is left untouched.
    assign err_c = (a > BCD_MAX) | (b > BCD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            bcd_sum   <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum     <= raw_lo_c;
                bcd_sum <= digit_c;
                cout    <= corr_c;
                err     <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_bcd_adder_df.sv
// Scoreboard bench for bcd_adder_df: expectations queued at drive time, popped when results appear.
module tb_bcd_adder_df;

    typedef struct packed {
        logic [3:0] sum;
        logic [3:0] bcd;
        logic       cout;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a, b;
    logic       cin;
    logic       out_valid;
    logic [3:0] sum, bcd_sum;
    logic       cout, err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t last_exp;

    always #5 clk = ~clk;

    bcd_adder_df dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .bcd_sum   (bcd_sum),
        .cout      (cout),
        .err       (err)
    );

    function automatic exp_t model(input int ia, input int ib, input int ic);
        exp_t e;
        int   raw;
        raw    = ia + ib + ic;
        e.sum  = 4'(raw % 16);
        e.cout = (raw > 9);
        e.bcd  = e.cout ? 4'((raw + 6) % 16) : 4'(raw % 16);
        e.err  = (ia > 9) || (ib > 9);
        return e;
    endfunction

    // Drive one cycle of stimulus; queue the expectation when the input will be accepted.
    task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tb_i, input logic tc);
        in_valid = v;
        a        = ta;
        b        = tb_i;
        cin      = tc;
        if (v && !rst) sb.push_back(model(int'(ta), int'(tb_i), int'(tc)));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'd9, 4'd9, 1'b1);
        drive(1'b1, 4'd7, 4'd8, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (sum !== 4'd0) begin n_errors++; $display("FAIL reset_sum got %h want 0", sum); end
        n_checks++;
        if (bcd_sum !== 4'd0) begin n_errors++; $display("FAIL reset_bcd_sum got %h want 0", bcd_sum); end
        n_checks++;
        if (cout !== 1'b0) begin n_errors++; $display("FAIL reset_cout got %b want 0", cout); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_vectors();
        logic [3:0] va[8] = '{4'd5, 4'd6, 4'd9, 4'd4, 4'd9, 4'd15, 4'd0, 4'd12};
        logic [3:0] vb[8] = '{4'd3, 4'd5, 4'd8, 4'd4, 4'd9, 4'd15, 4'd0, 4'd2};
        logic       vc[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, va[i], vb[i], vc[i]);
            n_checks++;
            if (out_valid !== 1'b1) begin n_errors++; $display("FAIL vec%0d_out_valid got %b want 1", i, out_valid); end
            if (sb.size() == 0) begin
                n_errors++; $display("FAIL vec%0d_scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                last_exp = e;
                n_checks++;
                if ({sum, bcd_sum, cout, err} !== {e.sum, e.bcd, e.cout, e.err}) begin
                    n_errors++;
                    $display("FAIL vec%0d a=%0d b=%0d cin=%0d got sum=%h bcd=%h cout=%b err=%b want sum=%h bcd=%h cout=%b err=%b",
                             i, va[i], vb[i], vc[i], sum, bcd_sum, cout, err, e.sum, e.bcd, e.cout, e.err);
                end
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    drive(1'b1, 4'(ia), 4'(ib), 1'(ic));
                    if (sb.size() == 0) begin
                        n_errors++; $display("FAIL sweep_scoreboard empty a=%0d b=%0d", ia, ib);
                    end else begin
                        e = sb.pop_front();
                        last_exp = e;
                        n_checks++;
                        if ({out_valid, sum, bcd_sum, cout, err} !== {1'b1, e.sum, e.bcd, e.cout, e.err}) begin
                            n_errors++;
                            $display("FAIL sweep a=%0d b=%0d cin=%0d got v=%b sum=%h bcd=%h cout=%b err=%b want v=1 sum=%h bcd=%h cout=%b err=%b",
                                     ia, ib, ic, out_valid, sum, bcd_sum, cout, err, e.sum, e.bcd, e.cout, e.err);
                        end
                    end
                end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va[3] = '{4'd7, 4'd2, 4'd8};
        logic [3:0] vb[3] = '{4'd7, 4'd3, 4'd1};
        logic       vc[3] = '{1'b1, 1'b0, 1'b1};
        exp_t e;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, va[i], vb[i], vc[i]);
            if (sb.size() == 0) begin
                n_errors++; $display("FAIL b2b%0d_scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                last_exp = e;
                n_checks++;
                if ({out_valid, sum, bcd_sum, cout, err} !== {1'b1, e.sum, e.bcd, e.cout, e.err}) begin
                    n_errors++;
                    $display("FAIL b2b%0d got v=%b sum=%h bcd=%h cout=%b want v=1 sum=%h bcd=%h cout=%b",
                             i, out_valid, sum, bcd_sum, cout, e.sum, e.bcd, e.cout);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'(3 + i), 4'(11 + i), 1'b1);
            n_checks++;
            if ({out_valid, sum, bcd_sum, cout, err} !== {1'b0, last_exp.sum, last_exp.bcd, last_exp.cout, last_exp.err}) begin
                n_errors++;
                $display("FAIL hold%0d got v=%b sum=%h bcd=%h cout=%b err=%b want v=0 sum=%h bcd=%h cout=%b err=%b",
                         i, out_valid, sum, bcd_sum, cout, err, last_exp.sum, last_exp.bcd, last_exp.cout, last_exp.err);
            end
        end
    endtask

    task automatic test_reset_pending();
        exp_t e;
        drive(1'b1, 4'd9, 4'd9, 1'b1);
        if (sb.size() == 0) begin
            n_errors++; $display("FAIL pre_rst_scoreboard empty");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, sum, bcd_sum, cout} !== {1'b1, e.sum, e.bcd, e.cout}) begin
                n_errors++;
                $display("FAIL pre_rst got v=%b sum=%h bcd=%h cout=%b want v=1 sum=%h bcd=%h cout=%b",
                         out_valid, sum, bcd_sum, cout, e.sum, e.bcd, e.cout);
            end
        end
        rst = 1'b1;
        drive(1'b1, 4'd15, 4'd15, 1'b1);
        n_checks++;
        if ({out_valid, sum, bcd_sum, cout, err} !== 11'd0) begin
            n_errors++;
            $display("FAIL rst_pending got v=%b sum=%h bcd=%h cout=%b err=%b want all 0",
                     out_valid, sum, bcd_sum, cout, err);
        end
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL post_rst_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        last_exp = '0;
        #1;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_sweep();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
